// File: rtl/div_seq.sv
// div_seq: 32-bit signed restoring divider (DIV) for the multi-cycle MIPS datapath.
// Optional divide-by-zero short-cut is enabled by defining DIV_ZERO_EN.
`timescale 1ns/1ps

module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_busy,
    output logic        div_done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_dvd;      // dividend magnitude, becomes the quotient bit by bit
    logic [31:0] r_dsr;
    logic [32:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_qsign;
    logic        r_rsign;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_zero;

    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_trial_neg;
    logic        w_b_zero;

    assign w_a_abs = a[31] ? (~a + 32'd1) : a;
    assign w_b_abs = b[31] ? (~b + 32'd1) : b;

    // The extra top bit keeps the trial subtraction's sign visible in bit 33.
    assign w_shift     = {1'b0, r_rem, r_dvd[31]};
    assign w_diff      = w_shift - {2'b00, r_dsr};
    assign w_trial_neg = w_diff[33];

`ifdef DIV_ZERO_EN
    assign w_b_zero = (b == 32'd0);
`else
    assign w_b_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        div_busy     = 1'b0;
        div_done     = 1'b0;
        div_zero     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div_start) begin
                    w_state_next = w_b_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                div_busy = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                div_busy     = 1'b1;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                div_done     = 1'b1;
                div_zero     = r_zero;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dvd   <= 32'd0;
            r_dsr   <= 32'd0;
            r_rem   <= 33'd0;
            r_cnt   <= 5'd0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_start) begin
                        r_dvd   <= w_a_abs;
                        r_dsr   <= w_b_abs;
                        r_qsign <= a[31] ^ b[31];
                        r_rsign <= a[31];
                        r_rem   <= 33'd0;
                        r_cnt   <= 5'd0;
                        r_zero  <= w_b_zero;
                    end
                end
                S_RUN: begin
                    r_rem <= w_trial_neg ? w_shift[32:0] : w_diff[32:0];
                    r_dvd <= {r_dvd[30:0], ~w_trial_neg};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    // Remainder magnitude is always below 2^32, so bit 32 is zero here.
                    r_lo <= r_qsign ? (~r_dvd + 32'd1) : r_dvd;
                    r_hi <= r_rsign ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against a magnitude/sign reference model.
`timescale 1ns/1ps

module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_busy;
    logic        div_done;
    logic        div_zero;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .div_start(div_start),
        .a        (a),
        .b        (b),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .div_busy (div_busy),
        .div_done (div_done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Reference: divide magnitudes, then apply MIPS signs (quotient a^b, remainder a).
    function automatic void predict(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic zero, output int lat, output int busy);
        logic [31:0] mx, my, qm, rm;
        mx = x[31] ? (32'd0 - x) : x;
        my = y[31] ? (32'd0 - y) : y;
        zero = 1'b0;
        lat  = 34;
        busy = 33;
        if (my == 32'd0) begin
            qm = 32'hFFFF_FFFF;
            rm = mx;
        end else begin
            qm = mx / my;
            rm = mx % my;
        end
        lo = (x[31] ^ y[31]) ? (32'd0 - qm) : qm;
        hi = x[31] ? (32'd0 - rm) : rm;
`ifdef DIV_ZERO_EN
        if (y == 32'd0) begin
            zero = 1'b1;
            lat  = 1;
            busy = 0;
            hi   = exp_hi;
            lo   = exp_lo;
        end
`endif
    endfunction

    // Pulses div_start at the current negedge and follows the run to completion.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int inject_at,
                          output int lat, output int busy_n, output int early_n,
                          output int stray_zero, output logic [31:0] hi_o,
                          output logic [31:0] lo_o, output logic zero_o,
                          output logic done_after);
        lat = 0; busy_n = 0; early_n = 0; stray_zero = 0;
        div_start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        div_start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (div_done !== 1'b1 && lat < 80) begin
            if (div_busy === 1'b1) busy_n++;
            if (hi_out !== exp_hi || lo_out !== exp_lo) early_n++;
            if (div_zero !== 1'b0) stray_zero++;
            if (lat == inject_at) begin
                div_start = 1'b1;
                a = $urandom;
                b = $urandom;
            end else begin
                div_start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        div_start = 1'b0;
        hi_o   = hi_out;
        lo_o   = lo_out;
        zero_o = div_zero;
        @(negedge clk);
        done_after = div_done;
    endtask

    task automatic test_reset;
        reset = 1'b1; div_start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        total++;
        if ({hi_out, lo_out} !== 64'd0 || {div_busy, div_done, div_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_values: got hi=%h lo=%h busy=%b done=%b zero=%b, required all zero",
                     hi_out, lo_out, div_busy, div_done, div_zero);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (div_busy !== 1'b0 || div_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", div_busy, div_done);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ta [8] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                                32'h8000_0000, 32'd5, 32'd7, 32'd100};
        logic [31:0] tb [8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'd1, 32'd0, 32'd0, 32'd7};
        int lat, busy_n, early_n, stray, elat, ebusy;
        logic [31:0] hi, lo, ehi, elo;
        logic z, ez, dafter;
        for (int i = 0; i < 8; i++) begin
            predict(ta[i], tb[i], ehi, elo, ez, elat, ebusy);
            run_op(ta[i], tb[i], 0, lat, busy_n, early_n, stray, hi, lo, z, dafter);
            total++;
            if (hi !== ehi || lo !== elo) begin
                bad++;
                $display("FAIL directed_result a=%h b=%h: got hi=%h lo=%h, required hi=%h lo=%h",
                         ta[i], tb[i], hi, lo, ehi, elo);
            end
            total++;
            if (lat !== elat || busy_n !== ebusy) begin
                bad++;
                $display("FAIL directed_timing a=%h b=%h: got done_cycle=%0d busy=%0d, required %0d %0d",
                         ta[i], tb[i], lat, busy_n, elat, ebusy);
            end
            total++;
            if (z !== ez || stray !== 0 || dafter !== 1'b0 || early_n !== 0) begin
                bad++;
                $display("FAIL directed_flags a=%h b=%h: got zero=%b stray_zero=%0d done_next=%b early_out_change=%0d, required %b 0 0 0",
                         ta[i], tb[i], z, stray, dafter, early_n, ez);
            end
            exp_hi = ehi;
            exp_lo = elo;
            $display("op a=%h b=%h -> hi=%h lo=%h done_cycle=%0d", ta[i], tb[i], hi, lo, lat);
        end
    endtask

    task automatic test_random;
        int lat, busy_n, early_n, stray, elat, ebusy;
        logic [31:0] x, y, hi, lo, ehi, elo;
        logic z, ez, dafter;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin x = $urandom; y = $urandom; end
                1: begin x = $urandom; y = $urandom_range(0, 15); end
                2: begin x = $urandom_range(0, 1000) - 500; y = $urandom_range(0, 40) - 20; end
                default: begin x = 32'h8000_0000 ^ $urandom_range(0, 3); y = $urandom; end
            endcase
            predict(x, y, ehi, elo, ez, elat, ebusy);
            run_op(x, y, 0, lat, busy_n, early_n, stray, hi, lo, z, dafter);
            total++;
            if (hi !== ehi || lo !== elo || lat !== elat || z !== ez) begin
                bad++;
                $display("FAIL random_op a=%h b=%h: got hi=%h lo=%h cycle=%0d zero=%b, required hi=%h lo=%h cycle=%0d zero=%b",
                         x, y, hi, lo, lat, z, ehi, elo, elat, ez);
            end
            exp_hi = ehi;
            exp_lo = elo;
            $display("op a=%h b=%h -> hi=%h lo=%h done_cycle=%0d", x, y, hi, lo, lat);
        end
    endtask

    task automatic test_ignore_start;
        int lat, busy_n, early_n, stray, elat, ebusy;
        logic [31:0] hi, lo, ehi, elo;
        logic z, ez, dafter;
        predict(32'd1000, 32'd33, ehi, elo, ez, elat, ebusy);
        run_op(32'd1000, 32'd33, 10, lat, busy_n, early_n, stray, hi, lo, z, dafter);
        total++;
        if (hi !== ehi || lo !== elo || lat !== elat || busy_n !== ebusy || early_n !== 0) begin
            bad++;
            $display("FAIL ignore_start: got hi=%h lo=%h cycle=%0d busy=%0d early=%0d, required hi=%h lo=%h cycle=%0d busy=%0d early=0",
                     hi, lo, lat, busy_n, early_n, ehi, elo, elat, ebusy);
        end
        exp_hi = ehi;
        exp_lo = elo;
        $display("op a=1000 b=33 with mid-run start -> hi=%h lo=%h done_cycle=%0d", hi, lo, lat);
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [3] = '{32'd12345, 32'hFFFF_0000, 32'd99};
        logic [31:0] tb [3] = '{32'd10, 32'd3, 32'hFFFF_FFF7};
        int lat, busy_n, early_n, stray, elat, ebusy;
        logic [31:0] hi, lo, ehi, elo;
        logic z, ez, dafter;
        for (int i = 0; i < 3; i++) begin
            predict(ta[i], tb[i], ehi, elo, ez, elat, ebusy);
            run_op(ta[i], tb[i], 0, lat, busy_n, early_n, stray, hi, lo, z, dafter);
            total++;
            if (hi !== ehi || lo !== elo || lat !== elat) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got hi=%h lo=%h cycle=%0d, required hi=%h lo=%h cycle=%0d",
                         i, hi, lo, lat, ehi, elo, elat);
            end
            exp_hi = ehi;
            exp_lo = elo;
            $display("op a=%h b=%h back-to-back -> hi=%h lo=%h done_cycle=%0d", ta[i], tb[i], hi, lo, lat);
        end
    endtask

    task automatic test_reset_midrun;
        int lat, busy_n, early_n, stray, elat, ebusy;
        logic [31:0] hi, lo, ehi, elo;
        logic z, ez, dafter;
        div_start = 1'b1; a = 32'd123456; b = 32'd789;
        @(negedge clk);
        div_start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({hi_out, lo_out} !== 64'd0 || div_busy !== 1'b0 || div_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun: got hi=%h lo=%h busy=%b done=%b, required 0 0 0 0",
                     hi_out, lo_out, div_busy, div_done);
        end
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (div_busy !== 1'b0 || {hi_out, lo_out} !== 64'd0) begin
            bad++;
            $display("FAIL reset_stays_idle: got busy=%b hi=%h lo=%h, required 0 0 0", div_busy, hi_out, lo_out);
        end
        predict(32'd100, 32'd7, ehi, elo, ez, elat, ebusy);
        run_op(32'd100, 32'd7, 0, lat, busy_n, early_n, stray, hi, lo, z, dafter);
        total++;
        if (hi !== 32'd2 || lo !== 32'd14 || lat !== elat) begin
            bad++;
            $display("FAIL after_reset_op: got hi=%h lo=%h cycle=%0d, required hi=2 lo=14 cycle=%0d",
                     hi, lo, lat, elat);
        end
        exp_hi = ehi;
        exp_lo = elo;
        $display("op a=100 b=7 after reset -> hi=%h lo=%h done_cycle=%0d", hi, lo, lat);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
